// File: rtl/axi_acc_slave.sv
// AXI3 slave over a DEPTH x 32 scratch RAM; independent one-outstanding write and read FSMs.
// Write: wready the cycle after AW, bvalid the cycle after the last W. Read: one beat per 2 cycles. Outputs hold while ready is low.
module axi_acc_slave #(
  parameter int DEPTH  = 256,
  parameter int AW_IDX = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  acc_awid,
  input  logic [31:0] acc_awaddr,
  input  logic [7:0]  acc_awlen,
  input  logic [2:0]  acc_awsize,
  input  logic [1:0]  acc_awburst,
  input  logic        acc_awvalid,
  output logic        acc_awready,
  input  logic [3:0]  acc_wid,
  input  logic [31:0] acc_wdata,
  input  logic [3:0]  acc_wstrb,
  input  logic        acc_wlast,
  input  logic        acc_wvalid,
  output logic        acc_wready,
  output logic [3:0]  acc_bid,
  output logic [1:0]  acc_bresp,
  output logic        acc_bvalid,
  input  logic        acc_bready,
  input  logic [3:0]  acc_arid,
  input  logic [31:0] acc_araddr,
  input  logic [7:0]  acc_arlen,
  input  logic [2:0]  acc_arsize,
  input  logic [1:0]  acc_arburst,
  input  logic        acc_arvalid,
  output logic        acc_arready,
  output logic [3:0]  acc_rid,
  output logic [31:0] acc_rdata,
  output logic [1:0]  acc_rresp,
  output logic        acc_rlast,
  output logic        acc_rvalid,
  input  logic        acc_rready
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  logic [31:0] mem [DEPTH];

  wstate_t           wstate;
  logic [AW_IDX-1:0] w_idx;
  logic [7:0]        w_len, w_cnt;
  logic              w_fixed, w_err, w_last;

  rstate_t           rstate;
  logic [AW_IDX-1:0] r_idx;
  logic [7:0]        r_len, r_cnt;
  logic              r_fixed, r_err;

  logic unused_bits;
  assign unused_bits = ^{acc_wid, acc_awaddr[31:AW_IDX+2], acc_awaddr[1:0],
                         acc_araddr[31:AW_IDX+2], acc_araddr[1:0]};

  // Only 32-bit INCR/FIXED bursts are supported; WRAP and the reserved encoding error out.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (size != 3'b010);
  endfunction

  assign w_last      = (w_cnt == w_len);
  assign acc_awready = (wstate == W_IDLE);
  assign acc_wready  = (wstate == W_DATA);
  assign acc_bvalid  = (wstate == W_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      acc_bid   <= '0;
      acc_bresp <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_fixed   <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (acc_awvalid) begin
          acc_bid <= acc_awid;
          w_idx   <= acc_awaddr[AW_IDX+1:2];
          w_len   <= acc_awlen;
          w_cnt   <= '0;
          w_fixed <= (acc_awburst == 2'b00);
          w_err   <= req_err(acc_awsize, acc_awburst);
          wstate  <= W_DATA;
        end
        W_DATA: if (acc_wvalid) begin
          w_cnt <= w_cnt + 8'd1;
          if (!w_fixed) w_idx <= w_idx + 1'b1;
          if (acc_wlast != w_last) w_err <= 1'b1;
          // The burst length comes from awlen; a stray wlast only flags an error.
          if (w_last) begin
            acc_bresp <= (w_err || !acc_wlast) ? 2'b10 : 2'b00;
            wstate    <= W_RESP;
          end
        end
        W_RESP: if (acc_bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wvalid && acc_wready && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[w_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign acc_arready = (rstate == R_IDLE);
  assign acc_rvalid  = (rstate == R_DATA);
  assign acc_rlast   = (rstate == R_DATA) && (r_cnt == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      acc_rid   <= '0;
      acc_rdata <= '0;
      acc_rresp <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_fixed   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (acc_arvalid) begin
          acc_rid <= acc_arid;
          r_idx   <= acc_araddr[AW_IDX+1:2];
          r_len   <= acc_arlen;
          r_cnt   <= '0;
          r_fixed <= (acc_arburst == 2'b00);
          r_err   <= req_err(acc_arsize, acc_arburst);
          rstate  <= R_FETCH;
        end
        R_FETCH: begin
          acc_rdata <= r_err ? '0 : mem[r_idx];
          acc_rresp <= r_err ? 2'b10 : 2'b00;
          rstate    <= R_DATA;
        end
        R_DATA: if (acc_rready) begin
          if (acc_rlast) begin
            rstate <= R_IDLE;
          end else begin
            if (!r_fixed) r_idx <= r_idx + 1'b1;
            r_cnt  <= r_cnt + 8'd1;
            rstate <= R_FETCH;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
